// File: rtl/aer_event_encoder.sv
// aer_event_encoder
// Turns column grants from the arbitration tree into timestamped address-event
// words. Turns group releases into group-end markers. Drops are reported with a
// single overflow marker. All words are queued in a first-word-fall-through FIFO
// and streamed out over a valid/ready handshake.
module aer_event_encoder #(
    parameter  int Lvl_ROW_ADD = 1,
    parameter  int Lvl_COL_ADD = 1,
    parameter  int TS_WIDTH    = 16,
    parameter  int FIFO_DEPTH  = 8,
    localparam int EVT_W       = 2 + TS_WIDTH + Lvl_ROW_ADD + Lvl_COL_ADD + 1,
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic                   gnt_valid_i,
    input  logic [Lvl_ROW_ADD-1:0] xadd_i,
    input  logic [Lvl_COL_ADD-1:0] yadd_i,
    input  logic                   polarity_i,
    input  logic                   grp_release_i,
    output logic [EVT_W-1:0]       evt_data_o,
    output logic                   evt_valid_o,
    input  logic                   evt_ready_i,
    output logic [CNT_W-1:0]       fifo_count_o,
    output logic [15:0]            drop_cnt_o,
    output logic                   overflow_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [1:0] TYPE_EVT = 2'b01;
    localparam logic [1:0] TYPE_GRP = 2'b10;
    localparam logic [1:0] TYPE_OVF = 2'b11;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // Drop counter sticks at its maximum instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // FIFO depth is a power of two, so the natural binary wrap of a PTR_W-wide
    // pointer is exactly modulo FIFO_DEPTH.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return p + PTR_W'(1);
    endfunction

    logic [TS_WIDTH-1:0] ts_q;
    logic                grp_rel_q;
    logic                marker_pend_q;
    logic                overflow_q;
    logic [15:0]         drop_cnt_q;

    logic [EVT_W-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [CNT_W-1:0]    count_q;

    // Capture-stage signals: what gets written into the FIFO this cycle.
    logic                evt_req_p0;
    logic                grp_req_p0;
    logic                ovf_req_p0;
    logic                pop_p0;
    logic                space_p0;
    logic                wr_vld_p0;
    logic [EVT_W-1:0]    wr_word_p0;
    logic                drop_p0;
    logic                grp_edge_p0;
    logic                grp_done_p0;
    logic                ovf_done_p0;

    // Write arbitration: one word per cycle, event beats group-end beats overflow.
    always_comb begin
        evt_req_p0  = enable_i & gnt_valid_i;
        grp_req_p0  = marker_pend_q & ~evt_req_p0;
        ovf_req_p0  = overflow_q & ~evt_req_p0 & ~grp_req_p0;
        pop_p0      = (count_q != '0) & evt_ready_i;
        // A full FIFO can still take a word when the head leaves in the same cycle.
        space_p0    = (count_q < DEPTH_C) | pop_p0;
        grp_edge_p0 = enable_i & grp_release_i & ~grp_rel_q;

        wr_vld_p0   = 1'b0;
        wr_word_p0  = '0;
        drop_p0     = 1'b0;
        grp_done_p0 = 1'b0;
        ovf_done_p0 = 1'b0;

        if (evt_req_p0) begin
            if (space_p0) begin
                wr_vld_p0  = 1'b1;
                wr_word_p0 = {TYPE_EVT, ts_q, xadd_i, yadd_i, polarity_i};
            end else begin
                drop_p0    = 1'b1;
            end
        end else if (grp_req_p0) begin
            // Markers are never dropped: if refused they simply stay pending.
            if (space_p0) begin
                wr_vld_p0   = 1'b1;
                grp_done_p0 = 1'b1;
                wr_word_p0  = {TYPE_GRP, ts_q, xadd_i, {Lvl_COL_ADD{1'b0}}, 1'b0};
            end
        end else if (ovf_req_p0) begin
            if (space_p0) begin
                wr_vld_p0   = 1'b1;
                ovf_done_p0 = 1'b1;
                wr_word_p0  = {TYPE_OVF, ts_q, {(Lvl_ROW_ADD + Lvl_COL_ADD + 1){1'b0}}};
            end
        end
    end

    // Free-running timestamp, advancing only while capture is enabled.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ts_q <= '0;
        end else if (enable_i) begin
            ts_q <= ts_q + TS_WIDTH'(1);
        end
    end

    // Group release edge detection; a fresh edge outranks the clear from a write.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            grp_rel_q     <= 1'b0;
            marker_pend_q <= 1'b0;
        end else begin
            grp_rel_q <= grp_release_i;
            if (grp_edge_p0) begin
                marker_pend_q <= 1'b1;
            end else if (grp_done_p0) begin
                marker_pend_q <= 1'b0;
            end
        end
    end

    // Drop bookkeeping; a drop and an overflow-marker write can never coincide.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (drop_p0) begin
                overflow_q <= 1'b1;
                drop_cnt_q <= sat_inc16(drop_cnt_q);
            end else if (ovf_done_p0) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_vld_p0) begin
                wr_ptr_q <= ptr_next(wr_ptr_q);
            end
            if (pop_p0) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            case ({wr_vld_p0, pop_p0})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are qualified by the pointers, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (wr_vld_p0) begin
            mem[wr_ptr_q] <= wr_word_p0;
        end
    end

    // Output stage: head of FIFO, forced to zero while empty.
    always_comb begin
        evt_valid_o  = (count_q != '0);
        evt_data_o   = evt_valid_o ? mem[rd_ptr_q] : '0;
        fifo_count_o = count_q;
        drop_cnt_o   = drop_cnt_q;
        overflow_o   = overflow_q;
    end

endmodule

// File: tb/tb_aer_event_encoder.sv
// tb_aer_event_encoder
// Scoreboard bench: the driver runs a word-level model of the encoder and
// queues every word it expects; an independent monitor pops and compares each
// word the DUT hands over on the valid/ready link.
module tb_aer_event_encoder;

    localparam int DEPTH = 8;
    localparam int EW    = 21;
    localparam int CNTW  = 4;

    logic            clk = 1'b0;
    logic            reset_i = 1'b1;
    logic            enable_i = 1'b0;
    logic            gnt_valid_i = 1'b0;
    logic [0:0]      xadd_i = '0;
    logic [0:0]      yadd_i = '0;
    logic            polarity_i = 1'b0;
    logic            grp_release_i = 1'b0;
    logic            evt_ready_i = 1'b0;
    logic [EW-1:0]   evt_data_o;
    logic            evt_valid_o;
    logic [CNTW-1:0] fifo_count_o;
    logic [15:0]     drop_cnt_o;
    logic            overflow_o;

    always #5 clk = ~clk;

    aer_event_encoder #(
        .Lvl_ROW_ADD(1), .Lvl_COL_ADD(1), .TS_WIDTH(16), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i),
        .gnt_valid_i(gnt_valid_i), .xadd_i(xadd_i), .yadd_i(yadd_i),
        .polarity_i(polarity_i), .grp_release_i(grp_release_i),
        .evt_data_o(evt_data_o), .evt_valid_o(evt_valid_o),
        .evt_ready_i(evt_ready_i), .fifo_count_o(fifo_count_o),
        .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    // Reference model state (values the DUT should show after the last edge).
    logic [15:0] m_ts   = '0;
    int          m_cnt  = 0;
    int          m_drop = 0;
    logic        m_pend = 1'b0;
    logic        m_ovf  = 1'b0;
    logic        m_grpq = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare visible state, advance the model.
    task automatic cyc(input logic rst, input logic en, input logic gv, input logic x,
                       input logic y, input logic pol, input logic grp, input logic rdy);
        logic          ev, ge, ov, pop, space, push;
        logic [EW-1:0] w;
        @(posedge clk);
        #1;
        reset_i = rst; enable_i = en; gnt_valid_i = gv; xadd_i = x; yadd_i = y;
        polarity_i = pol; grp_release_i = grp; evt_ready_i = rdy;

        chk("count", 32'(fifo_count_o), 32'(m_cnt));
        chk("valid", 32'(evt_valid_o), 32'(m_cnt > 0));
        chk("drop_cnt", 32'(drop_cnt_o), 32'(m_drop));
        chk("overflow", 32'(overflow_o), 32'(m_ovf));
        if (!evt_valid_o) chk("idle_data", 32'(evt_data_o), 32'd0);

        if (rst) begin
            exp_q.delete();
            m_ts = '0; m_cnt = 0; m_drop = 0; m_pend = 1'b0; m_ovf = 1'b0; m_grpq = 1'b0;
        end else begin
            push  = 1'b0;
            w     = '0;
            ev    = en & gv;
            ge    = m_pend & ~ev;
            ov    = m_ovf & ~ev & ~ge;
            pop   = (m_cnt > 0) && rdy;
            space = (m_cnt < DEPTH) || pop;
            if (ev) begin
                if (space) begin
                    w = {2'b01, m_ts, x, y, pol}; push = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
            end else if (ge) begin
                if (space) begin
                    w = {2'b10, m_ts, x, 1'b0, 1'b0}; push = 1'b1; m_pend = 1'b0;
                end
            end else if (ov && space) begin
                w = {2'b11, m_ts, 3'b000}; push = 1'b1; m_ovf = 1'b0;
            end
            if (push) exp_q.push_back(w);
            m_cnt = m_cnt + int'(push) - int'(pop);
            if (grp && !m_grpq && en) m_pend = 1'b1;
            m_grpq = grp;
            if (en) m_ts = m_ts + 16'd1;
        end
    endtask

    // Monitor: every handshake the DUT completes must match the oldest expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_i && evt_valid_o && evt_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h expected none", evt_data_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("word", 32'(evt_data_o), 32'(mon_e));
                end
            end
        end
    end

    initial begin
        logic r_en, r_gv, r_x, r_y, r_p, r_g, r_r;

        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);

        // Single event at ts=5 with an always-ready sink.
        repeat (5) cyc(0, 1, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 1, 1, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("first_valid", 32'(evt_valid_o), 32'd1);
        chk("first_word", 32'(evt_data_o), 32'({2'b01, 16'd5, 3'b101}));
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("first_gone", 32'(evt_valid_o), 32'd0);

        // Ten grants into a stalled sink: eight stored, two dropped.
        for (int i = 0; i < 10; i++) cyc(0, 1, 1, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("full_count", 32'(fifo_count_o), 32'd8);
        chk("drop_two", 32'(drop_cnt_o), 32'd2);
        chk("ovf_set", 32'(overflow_o), 32'd1);
        repeat (12) cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("ovf_clear", 32'(overflow_o), 32'd0);
        chk("drained", 32'(fifo_count_o), 32'd0);

        // Group release rising with a grant, then held high.
        cyc(0, 1, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 1, 1, 1, 0, 1, 1);
        repeat (5) cyc(0, 1, 0, 1, 0, 0, 1, 1);

        // Full FIFO with simultaneous pop and push.
        for (int i = 0; i < 8; i++) cyc(0, 1, 1, 1'($urandom), 1'($urandom), 1'($urandom), 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 1, 0);
        chk("full_again", 32'(fifo_count_o), 32'd8);
        cyc(0, 1, 1, 0, 1, 1, 1, 1);
        cyc(0, 1, 0, 0, 0, 0, 1, 0);
        chk("full_pop_push_count", 32'(fifo_count_o), 32'd8);
        chk("full_pop_push_drop", 32'(drop_cnt_o), 32'd2);
        repeat (10) cyc(0, 1, 0, 0, 0, 0, 0, 1);

        // Walk the timestamp to FFFE, then grants across the wrap and a hold.
        for (int i = 0; i < 70000 && m_ts != 16'hFFFE; i++) cyc(0, 1, 0, 0, 0, 0, 0, 1);
        chk("ts_reached", 32'(m_ts), 32'h0000FFFE);
        cyc(0, 1, 1, 0, 1, 0, 0, 1);
        cyc(0, 1, 1, 1, 0, 1, 0, 1);
        cyc(0, 1, 1, 1, 1, 1, 1, 1);
        repeat (4) cyc(0, 0, 0, 1, 0, 0, 1, 1);
        cyc(0, 1, 1, 0, 0, 1, 1, 1);
        repeat (4) cyc(0, 0, 0, 0, 0, 0, 0, 1);

        // Randomized traffic with back-pressure and group activity.
        for (int i = 0; i < 3000; i++) begin
            r_en = ($urandom_range(0, 7) != 0);
            r_gv = 1'($urandom);
            r_x  = 1'($urandom);
            r_y  = 1'($urandom);
            r_p  = 1'($urandom);
            r_g  = ($urandom_range(0, 3) == 0) ? ~grp_release_i : grp_release_i;
            r_r  = ($urandom_range(0, 2) != 0);
            cyc(0, r_en, r_gv, r_x, r_y, r_p, r_g, r_r);
        end
        repeat (20) cyc(0, 0, 0, 0, 0, 0, 0, 1);

        // Reset while four words are queued and the sink is stalled.
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("four_queued", 32'(fifo_count_o), 32'd4);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 1, 0, 0, 0);
        chk("rst_valid", 32'(evt_valid_o), 32'd0);
        chk("rst_count", 32'(fifo_count_o), 32'd0);
        chk("rst_drop", 32'(drop_cnt_o), 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_ts_word", 32'(evt_data_o), 32'({2'b01, 16'd0, 3'b110}));
        repeat (6) cyc(0, 0, 0, 0, 0, 0, 0, 1);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
